sr_button_conditioner: RTL and testbench
========================================

# sr_button_conditioner

Conditions two raw, asynchronous, bouncing pushbutton inputs (set and reset) into clean, mutually exclusive, single-cycle `s`/`r` pulses. It sits directly upstream of the `srgate` SR latch and drives its `S` and `R` inputs. Because of this block, the latch never sees bounce, metastable levels or the illegal S=R=1 combination. It also reports attempted conflicts on a flag.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 16: number of consecutive clock edges a synchronised input must hold a new level before it is accepted; legal range 1..65535.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `set_raw`  in  1  raw set button, asynchronous to `clk`, active-high.
- `reset_raw`  in  1  raw reset button, asynchronous to `clk`, active-high.
- `s`  out  1  single-cycle set pulse, drives `srgate.S`.
- `r`  out  1  single-cycle reset pulse, drives `srgate.R`.
- `set_level`  out  1  debounced level of the set button.
- `reset_level`  out  1  debounced level of the reset button.
- `conflict`  out  1  single-cycle pulse when a press is suppressed due to the other button being held.

## Operation
- Each channel (set, reset) is identical:
  - 2-flop synchroniser.
  - Debounce counter of width `$clog2(DEBOUNCE_CYCLES+1)`.
  - Stable-level register.
- Debounce rules:
  - Counter resets to 0 on any edge where the synchronised value equals the stable level.
  - Otherwise the counter increments.
  - When the counter would reach `DEBOUNCE_CYCLES`, the stable level toggles and the counter clears.
  - The counter saturates; it never wraps.
- Per-channel FSM:
  - IDLE: stable 0, counter 0.
  - ARMING: synchronised 1 ≠ stable 0, counting.
    - Return to IDLE if the input drops before acceptance.
    - Go to HELD on acceptance.
  - HELD: stable 1.
  - RELEASING: synchronised 0 ≠ stable 1, counting.
    - Back to HELD on bounce.
    - Go to IDLE on acceptance.
- Rising edge of stable level (ARMING→HELD):
  - Raises a candidate press for one cycle.
  - Falling-edge acceptance produces no pulse.
- Arbitration, evaluated on candidates and the *pre-update* stable levels:
  - Set candidate, other channel not HELD/RELEASING, no reset candidate → `s`=1.
  - Reset candidate under the same rules → `r`=1.
  - Candidate while the other channel is HELD or RELEASING → pulse suppressed, `conflict`=1.
  - Set and reset candidates on the same edge → both suppressed, `conflict`=1.
- `s` and `r` are never high in the same cycle under any input sequence.
- Reset mid-operation: on an edge with `rst_n`=0, all of the following clear on that edge regardless of FSM state:
  - synchronisers,
  - counters,
  - stable levels,
  - FSMs (to IDLE),
  - outputs.

  No pulse is generated by the reset itself or by inputs already held high when reset releases. A button held through reset produces a pulse `DEBOUNCE_CYCLES+2` edges after release, the same as a fresh press.

## Timing
- Reset values: `s`=0, `r`=0, `set_level`=0, `reset_level`=0, `conflict`=0.
- Latency:
  - Raw input first sampled high at edge 0 and held clean.
  - Synchronised value is 1 after edge 1.
  - Stable level is 1 after edge `DEBOUNCE_CYCLES+1`.
  - `s`/`r` are high for exactly the cycle after edge `DEBOUNCE_CYCLES+2`.
- `set_level`/`reset_level` are registered, one edge before the corresponding pulse.
- Release latency equals press latency. No pulse is generated on release.
- A glitch shorter than `DEBOUNCE_CYCLES` synchronised cycles never changes the stable level.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `sr_cond_pkg`:
  - FSM enum `chan_state_t` with values IDLE, ARMING, HELD, RELEASING.
  - Function `cnt_width(int n)` returning `$clog2(n+1)`.
- Sub-module `debounce_channel`, instantiated twice:
  - Contains the synchroniser, counter, FSM and stable register.
  - Outputs: `level`, `rise` (candidate) and `state`.
- Top level holds the arbitration and output registers only.

## Test plan
Run with `DEBOUNCE_CYCLES`=4.
1. Reset held 3 cycles with `set_raw`=1 → all outputs 0 throughout. After release, `s` pulses once at edge 6 after release; `set_level`=1.
2. Clean `set_raw` press held 20 cycles, then released → exactly one `s` pulse, 1 cycle wide. `set_level` falls 5 edges after release. No pulse on release.
3. `set_raw` bounce pattern 1,0,1,1,0,1,1,1,1,1 → no pulse during bounce. Single `s` pulse 4 stable cycles after the last 0. `r` stays 0.
4. Set held, then `reset_raw` pressed → `r` suppressed, one `conflict` pulse. Release set, then re-press reset → one `r` pulse, `conflict`=0.
5. `set_raw` and `reset_raw` asserted on the same edge → no `s`/`r`, one `conflict` pulse. Both `set_level` and `reset_level` are 1.
6. `rst_n` driven low while the set channel is in ARMING (counter=2) → next cycle all state and outputs are 0. No `s` pulse unless the press is re-debounced after release.

Source files
------------

// File: rtl/sr_cond_pkg.sv
// Shared types and helpers for the SR button conditioner.
package sr_cond_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMING    = 2'd1,
        HELD      = 2'd2,
        RELEASING = 2'd3
    } chan_state_t;

    // Width of a counter that must be able to hold the value n.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchroniser, saturating debounce counter,
// stable-level register, tracking FSM and a one-cycle rising-edge candidate.
module debounce_channel
    import sr_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        raw,
    output logic        level,
    output logic        rise,
    output chan_state_t state
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          level_q;
    logic          level_d;
    logic          rise_q;
    logic          rise_d;
    chan_state_t   state_q;
    chan_state_t   state_d;

    // Synchronise the asynchronous raw input into the clk domain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    // Debounce counter and stable level; accepting on the edge the count
    // would reach DEBOUNCE_CYCLES keeps the counter from ever passing it.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q >= CNT_LAST) begin
            level_d = ~level_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        rise_d = level_d & ~level_q;
    end

    // Channel FSM; acceptance is taken from level_d so it stays in step
    // with the counter even when DEBOUNCE_CYCLES is 1.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (sync2_q) state_d = level_d ? HELD : ARMING;
            end
            ARMING: begin
                if (!sync2_q)     state_d = IDLE;
                else if (level_d) state_d = HELD;
            end
            HELD: begin
                if (!sync2_q) state_d = level_d ? RELEASING : IDLE;
            end
            RELEASING: begin
                if (sync2_q)       state_d = HELD;
                else if (!level_d) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Register counter, level, candidate and state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            state_q <= IDLE;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            state_q <= state_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign state = state_q;

endmodule

// File: rtl/sr_button_conditioner.sv
// Conditions two bouncing buttons into clean, mutually exclusive s/r pulses
// for an SR latch, flagging presses suppressed by the other button.
module sr_button_conditioner
    import sr_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_raw,
    input  logic reset_raw,
    output logic s,
    output logic r,
    output logic set_level,
    output logic reset_level,
    output logic conflict
);

    logic        set_rise;
    logic        reset_rise;
    chan_state_t set_state;
    chan_state_t reset_state;
    logic        set_busy;
    logic        reset_busy;
    logic        s_q;
    logic        s_d;
    logic        r_q;
    logic        r_d;
    logic        conflict_q;
    logic        conflict_d;

    debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_set_chan (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (set_raw),
        .level (set_level),
        .rise  (set_rise),
        .state (set_state)
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_reset_chan (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (reset_raw),
        .level (reset_level),
        .rise  (reset_rise),
        .state (reset_state)
    );

    // Arbitrate candidates against the other channel's registered state.
    always_comb begin
        set_busy   = (set_state == HELD) || (set_state == RELEASING);
        reset_busy = (reset_state == HELD) || (reset_state == RELEASING);
        s_d        = set_rise & ~reset_rise & ~reset_busy;
        r_d        = reset_rise & ~set_rise & ~set_busy;
        conflict_d = (set_rise & (reset_rise | reset_busy))
                   | (reset_rise & (set_rise | set_busy));
    end

    // Register the pulse outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            s_q        <= s_d;
            r_q        <= r_d;
            conflict_q <= conflict_d;
        end
    end

    assign s        = s_q;
    assign r        = r_q;
    assign conflict = conflict_q;

endmodule

// File: tb/tb_sr_button_conditioner.sv
// Directed bench for sr_button_conditioner with DEBOUNCE_CYCLES = 4.
// Expected per-edge output vectors come from hand-scheduled events and are
// queued as each edge is driven, then compared after that edge.
module tb_sr_button_conditioner;

  logic clk;
  logic rst_n;
  logic set_raw;
  logic reset_raw;
  logic s;
  logic r;
  logic set_level;
  logic reset_level;
  logic conflict;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic ps [int];
  logic pr [int];
  logic pc [int];
  logic sl_chg [int];
  logic rl_chg [int];
  logic sl_exp = 1'b0;
  logic rl_exp = 1'b0;

  logic [4:0] exp_q [$];
  string      tag_q [$];
  int         cyc_q [$];

  sr_button_conditioner #(
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .set_raw     (set_raw),
    .reset_raw   (reset_raw),
    .s           (s),
    .r           (r),
    .set_level   (set_level),
    .reset_level (reset_level),
    .conflict    (conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input logic sv, input logic rv, input logic nv, input string tag);
    logic [4:0] e;
    set_raw   = sv;
    reset_raw = rv;
    rst_n     = nv;
    if (!nv) begin
      sl_exp = 1'b0;
      rl_exp = 1'b0;
    end
    if (sl_chg.exists(cyc)) sl_exp = sl_chg[cyc];
    if (rl_chg.exists(cyc)) rl_exp = rl_chg[cyc];
    e = {ps.exists(cyc) ? 1'b1 : 1'b0, pr.exists(cyc) ? 1'b1 : 1'b0,
         pc.exists(cyc) ? 1'b1 : 1'b0, sl_exp, rl_exp};
    exp_q.push_back(e);
    tag_q.push_back(tag);
    cyc_q.push_back(cyc);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic hold(input int unsigned n, input logic sv, input logic rv, input string tag);
    for (int unsigned i = 0; i < n; i++) tick(sv, rv, 1'b1, tag);
  endtask

  always @(negedge clk) begin
    logic [4:0] e;
    logic [4:0] obs;
    string      t;
    int         c;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      t   = tag_q.pop_front();
      c   = cyc_q.pop_front();
      obs = {s, r, conflict, set_level, reset_level};
      checks++;
      assert (obs === e) else begin
        failures++;
        $error("FAIL %s edge=%0d {s,r,conflict,set_level,reset_level} observed=%b expected=%b",
               t, c, obs, e);
      end
    end
  end

  initial begin
    int e0;
    int e1;
    logic bounce [10];
    bounce = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    rst_n     = 1'b0;
    set_raw   = 1'b0;
    reset_raw = 1'b0;

    // 1: reset held with set pressed, then press continues after release.
    for (int unsigned i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0, 1'b0, "reset_hold");
      checks++;
      if ({s, r, conflict, set_level, reset_level} !== '0) begin
        failures++;
        $error("FAIL reset_state edge=%0d outputs=%b expected all zero",
               cyc, {s, r, conflict, set_level, reset_level});
      end
    end
    e0 = cyc;
    sl_chg[e0 + 5] = 1'b1;
    ps[e0 + 6]     = 1'b1;
    hold(10, 1'b1, 1'b0, "held_through_reset");
    e1 = cyc;
    sl_chg[e1 + 5] = 1'b0;
    hold(10, 1'b0, 1'b0, "release_after_reset");

    // 2: clean press held 20 cycles, then released.
    e0 = cyc;
    sl_chg[e0 + 5] = 1'b1;
    ps[e0 + 6]     = 1'b1;
    hold(20, 1'b1, 1'b0, "clean_press");
    e1 = cyc;
    sl_chg[e1 + 5] = 1'b0;
    hold(12, 1'b0, 1'b0, "clean_release");

    // 3: bouncing press; acceptance counts from the last low sample.
    e0 = cyc;
    sl_chg[e0 + 10] = 1'b1;
    ps[e0 + 11]     = 1'b1;
    for (int unsigned i = 0; i < 10; i++) tick(bounce[i], 1'b0, 1'b1, "bounce");
    hold(6, 1'b1, 1'b0, "bounce_settled");
    e1 = cyc;
    sl_chg[e1 + 5] = 1'b0;
    hold(10, 1'b0, 1'b0, "bounce_release");

    // 4: reset pressed while set held, then re-pressed once set is gone.
    e0 = cyc;
    sl_chg[e0 + 5]  = 1'b1;
    ps[e0 + 6]      = 1'b1;
    hold(10, 1'b1, 1'b0, "set_held");
    rl_chg[e0 + 15] = 1'b1;
    pc[e0 + 16]     = 1'b1;
    hold(10, 1'b1, 1'b1, "reset_while_set_held");
    sl_chg[e0 + 25] = 1'b0;
    hold(2, 1'b0, 1'b1, "set_released");
    rl_chg[e0 + 27] = 1'b0;
    hold(8, 1'b0, 1'b0, "both_released");
    rl_chg[e0 + 35] = 1'b1;
    pr[e0 + 36]     = 1'b1;
    hold(10, 1'b0, 1'b1, "reset_repress");
    rl_chg[e0 + 45] = 1'b0;
    hold(10, 1'b0, 1'b0, "reset_release");

    // 5: both buttons on the same edge.
    e0 = cyc;
    sl_chg[e0 + 5]  = 1'b1;
    rl_chg[e0 + 5]  = 1'b1;
    pc[e0 + 6]      = 1'b1;
    hold(10, 1'b1, 1'b1, "simultaneous");
    sl_chg[e0 + 15] = 1'b0;
    rl_chg[e0 + 15] = 1'b0;
    hold(10, 1'b0, 1'b0, "simultaneous_release");

    // 6: reset while set is arming (counter at 2), press kept through it.
    hold(4, 1'b1, 1'b0, "arming");
    tick(1'b1, 1'b0, 1'b0, "reset_mid_arming");
    tick(1'b1, 1'b0, 1'b0, "reset_mid_arming");
    e0 = cyc;
    sl_chg[e0 + 5] = 1'b1;
    ps[e0 + 6]     = 1'b1;
    hold(10, 1'b1, 1'b0, "rearm_after_reset");
    e1 = cyc;
    sl_chg[e1 + 5] = 1'b0;
    hold(10, 1'b0, 1'b0, "final_release");

    fork
      wait (exp_q.size() == 0);
      repeat (10) @(posedge clk);
    join_any
    disable fork;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $error("FAIL scoreboard_drain wait expired with %0d expected vectors pending",
             exp_q.size());
    end

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
